// File: rtl/cpu_consts_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   mem_arb_state_t : arbiter FSM states
//   mem_owner_t     : which requester owns the outstanding transaction
//   GNT_IF / GNT_DM : bit positions in the grant vector from mem_arb_pick
package cpu_consts;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } mem_owner_t;

    localparam int GNT_IF = 0;
    localparam int GNT_DM = 1;

    function automatic mem_owner_t owner_of(input logic dm_win);
        return dm_win ? OWNER_DM : OWNER_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection for the data-memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin on ties (the requester
// that did not win last time); otherwise DM always beats IF.
// Ports:
//   if_req, dm_req : raw request lines
//   last_owner     : owner of the most recent grant
//   grant          : one-hot (or zero) grant vector, bits GNT_IF / GNT_DM
module mem_arb_pick
    import cpu_consts::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  mem_owner_t last_owner,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant = '0;
        if (if_req && dm_req) begin
            if (last_owner == OWNER_DM) begin
                grant[GNT_IF] = 1'b1;
            end else begin
                grant[GNT_DM] = 1'b1;
            end
        end else begin
            grant[GNT_IF] = if_req;
            grant[GNT_DM] = dm_req;
        end
    end
`else
    // Fixed priority: the memory stage holds the older instruction.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant = '0;
        if (dm_req) begin
            grant[GNT_DM] = 1'b1;
        end else if (if_req) begin
            grant[GNT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between instruction fetch (IF) and the
// load/store unit (DM). One transaction outstanding at a time: grant in
// IDLE, one-cycle registered mem_req_o, wait for mem_rvalid_i, then pulse
// the owner's rvalid one cycle later.
// Build option: MEM_ARB_RR_EN (round-robin tie break, see mem_arb_pick).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   if_req_i/if_addr_i    : fetch request; if_gnt_o comb grant pulse
//   if_rvalid_o/if_rdata_o: fetch data return
//   dm_req_i/dm_addr_i/dm_wr_i/dm_wr_data_i/dm_wr_strb_i : load/store request
//   dm_gnt_o, dm_rvalid_o/dm_rdata_o : grant, load data or store ack (data 0)
//   mem_req_o/mem_addr_o/mem_wr_o/mem_wr_data_o/mem_wr_strb_o : memory request
//   mem_rvalid_i/mem_rdata_i : memory response
//   spurious_rsp_o        : sticky, response seen while IDLE
module mem_arbiter
    import cpu_consts::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic              dm_wr_i,
    input  logic [DATA_W-1:0] dm_wr_data_i,
    input  logic [STRB_W-1:0] dm_wr_strb_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic [STRB_W-1:0] mem_wr_strb_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              spurious_rsp_o
);

    mem_arb_state_t state, state_nxt;
    mem_owner_t     owner, last_owner, grant_owner;
    logic [1:0]     pick_grant;
    logic           grant_any;
    logic           take_rsp;

    mem_arb_pick u_pick (
        .if_req     (if_req_i),
        .dm_req     (dm_req_i),
        .last_owner (last_owner),
        .grant      (pick_grant)
    );

    always_comb begin
        state_nxt = state;
        if_gnt_o  = 1'b0;
        dm_gnt_o  = 1'b0;
        take_rsp  = 1'b0;
        case (state)
            ARB_IDLE: begin
                // Grants are suppressed while reset is held so nothing is
                // handed out that the reset would immediately discard.
                if (!reset) begin
                    if_gnt_o = pick_grant[GNT_IF];
                    dm_gnt_o = pick_grant[GNT_DM];
                    if (|pick_grant) begin
                        state_nxt = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                // Zero-latency memory may answer in the issue cycle.
                if (mem_rvalid_i) begin
                    take_rsp  = 1'b1;
                    state_nxt = ARB_IDLE;
                end else begin
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid_i) begin
                    take_rsp  = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign grant_any   = if_gnt_o | dm_gnt_o;
    assign grant_owner = owner_of(dm_gnt_o);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARB_IDLE;
            owner          <= OWNER_IF;
            last_owner     <= OWNER_IF;
            mem_req_o      <= 1'b0;
            mem_addr_o     <= '0;
            mem_wr_o       <= 1'b0;
            mem_wr_data_o  <= '0;
            mem_wr_strb_o  <= '0;
            if_rvalid_o    <= 1'b0;
            if_rdata_o     <= '0;
            dm_rvalid_o    <= 1'b0;
            dm_rdata_o     <= '0;
            spurious_rsp_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req_o <= grant_any;

            if (grant_any) begin
                owner      <= grant_owner;
                last_owner <= grant_owner;
                if (dm_gnt_o) begin
                    mem_addr_o    <= dm_addr_i;
                    mem_wr_o      <= dm_wr_i;
                    mem_wr_data_o <= dm_wr_data_i;
                    mem_wr_strb_o <= dm_wr_strb_i;
                end else begin
                    mem_addr_o    <= if_addr_i;
                    mem_wr_o      <= 1'b0;
                    mem_wr_data_o <= '0;
                    mem_wr_strb_o <= '0;
                end
            end

            if_rvalid_o <= take_rsp && (owner == OWNER_IF);
            dm_rvalid_o <= take_rsp && (owner == OWNER_DM);
            if_rdata_o  <= (take_rsp && owner == OWNER_IF) ? mem_rdata_i : '0;
            // Store acknowledge carries no data.
            dm_rdata_o  <= (take_rsp && owner == OWNER_DM && !mem_wr_o) ? mem_rdata_i : '0;

            if (mem_rvalid_i && state == ARB_IDLE) begin
                spurious_rsp_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam int W_NONE = 0;
    localparam int W_IF   = 1;
    localparam int W_DM   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              dm_req_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic              dm_wr_i;
    logic [DATA_W-1:0] dm_wr_data_i;
    logic [STRB_W-1:0] dm_wr_strb_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic [STRB_W-1:0] mem_wr_strb_o;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              spurious_rsp_o;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_gnt_o      (if_gnt_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_rdata_o    (if_rdata_o),
        .dm_req_i      (dm_req_i),
        .dm_addr_i     (dm_addr_i),
        .dm_wr_i       (dm_wr_i),
        .dm_wr_data_i  (dm_wr_data_i),
        .dm_wr_strb_i  (dm_wr_strb_i),
        .dm_gnt_o      (dm_gnt_o),
        .dm_rvalid_o   (dm_rvalid_o),
        .dm_rdata_o    (dm_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_o      (mem_wr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .mem_wr_strb_o (mem_wr_strb_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .spurious_rsp_o(spurious_rsp_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level reference model.
    bit          m_valid = 1'b0;
    bit          m_busy, m_issued, m_spur, m_if_rv, m_dm_rv, m_wr;
    int          m_owner, m_last;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_strb;

    // Event log of DUT activity for the directed scenarios.
    int          gnt_cyc[$];
    int          gnt_who[$];
    int          req_cyc[$];
    int          rv_cyc[$];
    int          rv_who[$];
    logic [63:0] rv_data[$];

    // Memory responder.
    bit          rsp_auto = 1'b1;
    int          rsp_lat  = 1;
    int          rsp_cnt  = -1;
    bit          rsp_rand = 1'b1;
    logic [63:0] rsp_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic int winner();
        if (if_req_i && dm_req_i) begin
`ifdef MEM_ARB_RR_EN
            return (m_last == W_DM) ? W_IF : W_DM;
`else
            return W_DM;
`endif
        end
        if (dm_req_i) return W_DM;
        if (if_req_i) return W_IF;
        return W_NONE;
    endfunction

    task automatic clear_log();
        gnt_cyc.delete(); gnt_who.delete(); req_cyc.delete();
        rv_cyc.delete();  rv_who.delete();  rv_data.delete();
    endtask

    task automatic compare_and_model();
        int w;
        w = W_NONE;
        if (m_valid && !reset && !m_busy) w = winner();
        if (m_valid) begin
            chk("if_gnt", 64'(if_gnt_o), 64'(w == W_IF));
            chk("dm_gnt", 64'(dm_gnt_o), 64'(w == W_DM));
            chk("mem_req", 64'(mem_req_o), 64'(m_busy && !m_issued));
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_wr", 64'(mem_wr_o), 64'(m_wr));
            chk("mem_wr_data", mem_wr_data_o, m_wdata);
            chk("mem_wr_strb", 64'(mem_wr_strb_o), 64'(m_strb));
            chk("if_rvalid", 64'(if_rvalid_o), 64'(m_if_rv));
            chk("dm_rvalid", 64'(dm_rvalid_o), 64'(m_dm_rv));
            chk("spurious", 64'(spurious_rsp_o), 64'(m_spur));
            if (m_if_rv) begin
                chk("if_rdata", if_rdata_o, m_rdata);
                chk("dm_rdata_nonowner", dm_rdata_o, 64'd0);
            end
            if (m_dm_rv) begin
                chk("dm_rdata", dm_rdata_o, m_rdata);
                chk("if_rdata_nonowner", if_rdata_o, 64'd0);
            end
        end

        if (if_gnt_o) begin gnt_cyc.push_back(cyc); gnt_who.push_back(W_IF); end
        if (dm_gnt_o) begin gnt_cyc.push_back(cyc); gnt_who.push_back(W_DM); end
        if (mem_req_o) req_cyc.push_back(cyc);
        if (if_rvalid_o) begin rv_cyc.push_back(cyc); rv_who.push_back(W_IF); rv_data.push_back(if_rdata_o); end
        if (dm_rvalid_o) begin rv_cyc.push_back(cyc); rv_who.push_back(W_DM); rv_data.push_back(dm_rdata_o); end

        // State after the coming clock edge.
        if (reset) begin
            m_valid = 1'b1; m_busy = 1'b0; m_issued = 1'b0; m_spur = 1'b0;
            m_if_rv = 1'b0; m_dm_rv = 1'b0; m_wr = 1'b0;
            m_owner = W_IF; m_last = W_IF;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_strb = '0;
        end else if (m_valid) begin
            m_if_rv = 1'b0; m_dm_rv = 1'b0; m_rdata = '0;
            if (!m_busy) begin
                if (mem_rvalid_i) m_spur = 1'b1;
                if (w != W_NONE) begin
                    m_busy = 1'b1; m_issued = 1'b0; m_owner = w; m_last = w;
                    if (w == W_DM) begin
                        m_addr = dm_addr_i; m_wr = dm_wr_i; m_wdata = dm_wr_data_i; m_strb = dm_wr_strb_i;
                    end else begin
                        m_addr = if_addr_i; m_wr = 1'b0; m_wdata = '0; m_strb = '0;
                    end
                end
            end else begin
                m_issued = 1'b1;
                if (mem_rvalid_i) begin
                    m_busy = 1'b0;
                    if (m_owner == W_DM) m_dm_rv = 1'b1; else m_if_rv = 1'b1;
                    m_rdata = (m_owner == W_DM && m_wr) ? 64'd0 : mem_rdata_i;
                end
            end
        end
    endtask

    task automatic respond();
        if (rsp_auto) begin
            if (mem_req_o) rsp_cnt = (rsp_lat < 0) ? int'($urandom_range(3, 0)) : rsp_lat;
            if (rsp_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rsp_rand ? {$urandom, $urandom} : rsp_data;
                rsp_cnt      = -1;
            end else begin
                mem_rvalid_i = 1'b0;
                if (rsp_cnt > 0) rsp_cnt--;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare_and_model();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        mem_rvalid_i = 1'b0;
        rsp_cnt = -1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int s;
        int n_if;
        reset = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_addr_i = '0;
        dm_wr_i = 1'b0; dm_wr_data_i = '0; dm_wr_strb_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        do_reset(3);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_addr", mem_addr_o, 64'd0);
        chk("rst_mem_wr", 64'(mem_wr_o), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid_o, dm_rvalid_o}), 64'd0);
        chk("rst_spurious", 64'(spurious_rsp_o), 64'd0);
        chk("rst_gnt", 64'({if_gnt_o, dm_gnt_o}), 64'd0);

        // Single load, memory latency 2.
        rsp_auto = 1'b1; rsp_lat = 2; rsp_rand = 1'b0; rsp_data = 64'hDEADBEEF_00000001;
        clear_log();
        s = cyc + 1;
        dm_req_i = 1'b1; dm_addr_i = 64'h40; dm_wr_i = 1'b0;
        tick();
        dm_req_i = 1'b0;
        repeat (6) tick();
        chk("load_gnt_count", 64'(gnt_cyc.size()), 64'd1);
        if (gnt_cyc.size() >= 1) begin
            chk("load_gnt_cycle", 64'(gnt_cyc[0] - s), 64'd0);
            chk("load_gnt_who", 64'(gnt_who[0]), 64'(W_DM));
        end
        chk("load_req_count", 64'(req_cyc.size()), 64'd1);
        if (req_cyc.size() >= 1) chk("load_req_cycle", 64'(req_cyc[0] - s), 64'd1);
        chk("load_rv_count", 64'(rv_cyc.size()), 64'd1);
        if (rv_cyc.size() >= 1) begin
            chk("load_rv_cycle", 64'(rv_cyc[0] - s), 64'd4);
            chk("load_rv_who", 64'(rv_who[0]), 64'(W_DM));
            chk("load_rv_data", rv_data[0], 64'hDEADBEEF_00000001);
        end
        n_if = 0;
        foreach (rv_who[i]) if (rv_who[i] == W_IF) n_if++;
        chk("load_no_if_rvalid", 64'(n_if), 64'd0);

        // Store, memory latency 1.
        rsp_lat = 1; rsp_rand = 1'b1;
        clear_log();
        s = cyc + 1;
        dm_req_i = 1'b1; dm_addr_i = 64'h80; dm_wr_i = 1'b1;
        dm_wr_data_i = 64'h1122334455667788; dm_wr_strb_i = 8'h0F;
        tick();
        dm_req_i = 1'b0; dm_wr_i = 1'b0; dm_wr_data_i = {$urandom, $urandom}; dm_wr_strb_i = 8'hFF;
        chk("store_issue_req", 64'(mem_req_o), 64'd1);
        chk("store_issue_wr", 64'(mem_wr_o), 64'd1);
        chk("store_issue_addr", mem_addr_o, 64'h80);
        chk("store_issue_data", mem_wr_data_o, 64'h1122334455667788);
        chk("store_issue_strb", 64'(mem_wr_strb_o), 64'h0F);
        tick();
        chk("store_wait_req", 64'(mem_req_o), 64'd0);
        chk("store_wait_wr", 64'(mem_wr_o), 64'd1);
        chk("store_wait_addr", mem_addr_o, 64'h80);
        chk("store_wait_data", mem_wr_data_o, 64'h1122334455667788);
        repeat (4) tick();
        chk("store_rv_count", 64'(rv_cyc.size()), 64'd1);
        if (rv_cyc.size() >= 1) begin
            chk("store_rv_cycle", 64'(rv_cyc[0] - s), 64'd3);
            chk("store_rv_who", 64'(rv_who[0]), 64'(W_DM));
            chk("store_rv_data", rv_data[0], 64'd0);
        end

        // Tie: both requesting continuously.
        do_reset(2);
        rsp_auto = 1'b1; rsp_lat = 1;
        clear_log();
        if_req_i = 1'b1; dm_req_i = 1'b1; if_addr_i = 64'h1000; dm_addr_i = 64'h2000;
        for (int i = 0; i < 40 && gnt_who.size() < 4; i++) tick();
        drain(8);
        chk("tie_gnt_count", 64'(gnt_who.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_who.size()) begin
`ifdef MEM_ARB_RR_EN
                chk("tie_order", 64'(gnt_who[i]), 64'((i % 2 == 0) ? W_DM : W_IF));
`else
                chk("tie_order", 64'(gnt_who[i]), 64'(W_DM));
`endif
            end
        end

        // Back-to-back IF with zero-latency memory.
        rsp_lat = 0;
        clear_log();
        s = cyc + 1;
        if_req_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if_addr_i = {$urandom, $urandom};
            tick();
        end
        drain(3);
        chk("b2b_gnt_count", 64'(gnt_cyc.size()), 64'd4);
        chk("b2b_rv_count", 64'(rv_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_cyc.size()) chk("b2b_gnt_cycle", 64'(gnt_cyc[i] - s), 64'(2 * i));
            if (i < rv_cyc.size()) chk("b2b_rv_cycle", 64'(rv_cyc[i] - s), 64'(2 + 2 * i));
        end

        // Random traffic with occasional resets.
        rsp_lat = -1; rsp_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if_req_i     = 1'($urandom_range(1, 0));
            dm_req_i     = 1'($urandom_range(1, 0));
            if_addr_i    = {$urandom, $urandom};
            dm_addr_i    = {$urandom, $urandom};
            dm_wr_i      = 1'($urandom_range(1, 0));
            dm_wr_data_i = {$urandom, $urandom};
            dm_wr_strb_i = 8'($urandom);
            reset        = ($urandom_range(63, 0) == 0);
            tick();
        end
        reset = 1'b0;
        drain(8);

        // Spurious response while idle.
        do_reset(2);
        rsp_auto = 1'b0;
        clear_log();
        mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
        tick();
        mem_rvalid_i = 1'b0;
        repeat (4) tick();
        chk("spur_flag", 64'(spurious_rsp_o), 64'd1);
        chk("spur_no_gnt", 64'(gnt_cyc.size()), 64'd0);
        chk("spur_no_rvalid", 64'(rv_cyc.size()), 64'd0);

        // Reset while waiting for the memory.
        do_reset(2);
        rsp_auto = 1'b0;
        clear_log();
        dm_req_i = 1'b1; dm_wr_i = 1'b0; dm_addr_i = 64'h300;
        tick();
        dm_req_i = 1'b0;
        tick();
        tick();
        chk("rw_in_wait_req", 64'(mem_req_o), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
        tick();
        mem_rvalid_i = 1'b0;
        repeat (3) tick();
        chk("rw_no_rvalid", 64'(rv_cyc.size()), 64'd0);
        chk("rw_spurious", 64'(spurious_rsp_o), 64'd1);
        if_req_i = 1'b1; if_addr_i = 64'h500;
        #1;
        chk("rw_idle_gnt", 64'(if_gnt_o), 64'd1);
        rsp_auto = 1'b1; rsp_lat = 0;
        tick();
        drain(4);
        chk("rw_after_rv_count", 64'(rv_cyc.size()), 64'd1);
        if (rv_who.size() >= 1) chk("rw_after_rv_who", 64'(rv_who[0]), 64'(W_IF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
